// File: rtl/dac_spi_tx.sv
// dac_spi_tx: 16-bit SPI frame sender for an MCP49x1-style DAC.
// Ports: clk, rst (sync, active high); sample/sample_valid/sample_ready
//   handshake; dac_cs_n, dac_sclk (mode 0), dac_mosi (MSB first),
//   dac_ldac_n; frame_done pulses on the first GAP cycle.
// Build option: define DAC_SPI_TX_LDAC_EN to strobe dac_ldac_n low
//   during GAP; otherwise dac_ldac_n is tied low.
module dac_spi_tx #(
  parameter int         SCLK_HALF = 2,
  parameter logic [3:0] CFG       = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_ldac_n,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;

  localparam logic [7:0] PH_MAX = 8'(SCLK_HALF - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  ph_cnt;
  logic [3:0]  bit_cnt;
  logic        hi;
  logic [15:0] sr;
  logic        ph_end;
  logic        accept;
  logic        in_gap;

  assign ph_end = (ph_cnt == PH_MAX);
  assign accept = sample_valid && sample_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = SETUP;
      SETUP: if (ph_end) state_nx = SHIFT;
      SHIFT: if (ph_end && !hi && bit_cnt == 4'd15)
               state_nx = GAP;
      GAP:   if (ph_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // hi tracks the SCLK level inside SHIFT; the shift register
  // advances as the high phase ends so MOSI moves on the falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt  <= 8'd0;
      bit_cnt <= 4'd0;
      hi      <= 1'b0;
      sr      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          ph_cnt  <= 8'd0;
          bit_cnt <= 4'd0;
          hi      <= 1'b0;
          if (accept) sr <= {CFG, sample};
        end
        SETUP: begin
          if (ph_end) begin
            ph_cnt <= 8'd0;
            hi     <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (ph_end) begin
            ph_cnt <= 8'd0;
            if (hi) begin
              hi <= 1'b0;
              sr <= {sr[14:0], 1'b0};
            end else begin
              hi      <= (bit_cnt != 4'd15);
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            ph_cnt <= ph_cnt + 8'd1;
          end
        end
        GAP: begin
          hi <= 1'b0;
          if (ph_end) ph_cnt <= 8'd0;
          else        ph_cnt <= ph_cnt + 8'd1;
        end
        default: begin
          ph_cnt  <= 8'd0;
          bit_cnt <= 4'd0;
          hi      <= 1'b0;
        end
      endcase
    end
  end

  // rst forces the idle pin state immediately, not just after the edge.
  always_comb begin
    sample_ready = 1'b0;
    dac_cs_n     = 1'b1;
    dac_sclk     = 1'b0;
    dac_mosi     = 1'b0;
    frame_done   = 1'b0;
    in_gap       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:  sample_ready = 1'b1;
        SETUP: begin
          dac_cs_n = 1'b0;
          dac_mosi = sr[15];
        end
        SHIFT: begin
          dac_cs_n = 1'b0;
          dac_sclk = hi;
          dac_mosi = sr[15];
        end
        GAP: begin
          frame_done = (ph_cnt == 8'd0);
          in_gap     = 1'b1;
        end
        default: sample_ready = 1'b0;
      endcase
    end
  end

`ifdef DAC_SPI_TX_LDAC_EN
  assign dac_ldac_n = !in_gap;
`else
  logic unused_gap;
  assign unused_gap = in_gap;
  assign dac_ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: random + directed bench for dac_spi_tx at
// SCLK_HALF = 2, 1 and 255 against a cycle-offset reference model.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst_v [3] = '{1'b1, 1'b1, 1'b1};
  logic        val_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [11:0] smp_v [3] = '{12'd0, 12'd0, 12'd0};

  int done_a [3];
  int acc_a  [3];
  int gap_a  [3];
  int rise_a [3];
  int lw_a   [3];
  int lr_a   [3];
  int lc_a   [3];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int g, logic [31:0] act,
                     logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d] got %0h expected %0h cycle %0d",
               nm, g, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 255;
    logic ready, cs_n, sclk, mosi, ldac_n, done;

    dac_spi_tx #(.SCLK_HALF(H)) dut (
      .clk          (clk),
      .rst          (rst_v[g]),
      .sample       (smp_v[g]),
      .sample_valid (val_v[g]),
      .sample_ready (ready),
      .dac_cs_n     (cs_n),
      .dac_sclk     (sclk),
      .dac_mosi     (mosi),
      .dac_ldac_n   (ldac_n),
      .frame_done   (done)
    );

    bit          busy = 1'b0;
    int          k = 0;
    logic [15:0] f = 16'd0;
    int          last_acc = 0;
    int          n_done = 0, n_acc = 0, gap = 0;
    logic        p_sclk = 1'b0;
    int          c_rise = 0, c_cs = 0;
    logic [15:0] c_word = 16'd0;
    int          l_word = 0, l_rise = 0, l_cs = 0;

    assign done_a[g] = n_done;
    assign acc_a[g]  = n_acc;
    assign gap_a[g]  = gap;
    assign rise_a[g] = c_rise;
    assign lw_a[g]   = l_word;
    assign lr_a[g]   = l_rise;
    assign lc_a[g]   = l_cs;

    // k = cycles since the accepting edge; pins follow from k alone.
    function automatic logic [5:0] expv(bit b, int kk,
                                        logic [15:0] ff, logic r);
      int   j, i;
      logic rd, cs, sc, mo, ld, dn;
      rd = 0; cs = 1; sc = 0; mo = 0; dn = 0;
`ifdef DAC_SPI_TX_LDAC_EN
      ld = 1;
`else
      ld = 0;
`endif
      if (r) begin
        rd = 0;
      end else if (!b) begin
        rd = 1;
      end else if (kk <= H) begin
        cs = 0;
        mo = ff[15];
      end else if (kk <= 33 * H) begin
        j  = kk - H - 1;
        i  = j / (2 * H);
        cs = 0;
        sc = (j % (2 * H)) < H;
        if (sc)          mo = ff[15 - i];
        else if (i < 15) mo = ff[14 - i];
        else             mo = 0;
      end else begin
        dn = (kk == 33 * H + 1);
`ifdef DAC_SPI_TX_LDAC_EN
        ld = 0;
`endif
      end
      return {rd, cs, sc, mo, ld, dn};
    endfunction

    always begin
      @(posedge clk);
      if (rst_v[g]) begin
        busy = 0;
      end else if (busy) begin
        k++;
        if (k == 34 * H + 1) busy = 0;
      end else if (val_v[g]) begin
        busy = 1;
        k    = 1;
        f    = {4'b0011, smp_v[g]};
        gap  = cyc - last_acc;
        last_acc = cyc;
        n_acc++;
      end
      #1;
      chk("pins", g, {26'd0, ready, cs_n, sclk, mosi, ldac_n, done},
          {26'd0, expv(busy, k, f, rst_v[g])});
      if (done) begin
        n_done++;
        l_word = int'(c_word);
        l_rise = c_rise;
        l_cs   = c_cs;
      end
      if (cs_n) begin
        c_rise = 0;
        c_cs   = 0;
        c_word = 16'd0;
      end else begin
        c_cs++;
        if (sclk && !p_sclk) begin
          c_rise++;
          c_word = {c_word[14:0], mosi};
        end
      end
      p_sclk = sclk;
    end
  end

  task automatic send(int g, logic [11:0] d);
    int  prev;
    bit  ok;
    prev     = acc_a[g];
    ok       = 0;
    val_v[g] = 1'b1;
    smp_v[g] = d;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(posedge clk);
      #2;
      if (acc_a[g] != prev) ok = 1;
    end
    if (!ok) chk("accept_timeout", g, 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done(int g, int prev, int lim);
    bit ok;
    ok = 0;
    for (int n = 0; n < lim && !ok; n++) begin
      @(negedge clk);
      if (done_a[g] > prev) ok = 1;
    end
    if (!ok) chk("done_timeout", g, 0, 1);
  endtask

  initial begin
    int p, a;
    repeat (3) @(negedge clk);
    rst_v[0] = 0; rst_v[1] = 0; rst_v[2] = 0;
    @(negedge clk);

    send(1, 12'h001);
    val_v[1] = 0;
    send(2, 12'h001);
    val_v[2] = 0;

    p = done_a[0];
    send(0, 12'hA5C);
    val_v[0] = 0;
    wait_done(0, p, 200);
    chk("word_a5c", 0, lw_a[0], 32'h3A5C);
    chk("rises_a5c", 0, lr_a[0], 16);
    chk("cslow_a5c", 0, lc_a[0], 66);
    chk("done_once", 0, done_a[0], p + 1);

    chk("word_h1", 1, lw_a[1], 32'h3001);
    chk("cslow_h1", 1, lc_a[1], 33);

    p = done_a[0];
    send(0, 12'h000);
    smp_v[0] = 12'hFFF;
    wait_done(0, p, 200);
    chk("word_000", 0, lw_a[0], 32'h3000);
    p = done_a[0];
    send(0, 12'hFFF);
    val_v[0] = 0;
    chk("b2b_gap", 0, gap_a[0], 69);
    wait_done(0, p, 200);
    chk("word_fff", 0, lw_a[0], 32'h3FFF);

    p = done_a[0];
    send(0, 12'h800);
    a = acc_a[0];
    smp_v[0] = 12'h123;
    repeat (20) @(negedge clk);
    val_v[0] = 0;
    wait_done(0, p, 200);
    chk("word_800", 0, lw_a[0], 32'h3800);
    chk("no_midaccept", 0, acc_a[0], a);

    p = done_a[0];
    send(0, 12'hAAA);
    val_v[0] = 0;
    for (int n = 0; n < 200 && rise_a[0] < 5; n++) @(negedge clk);
    chk("five_rises", 0, rise_a[0], 5);
    rst_v[0] = 1;
    val_v[0] = 1;
    @(negedge clk);
    rst_v[0] = 0;
    val_v[0] = 0;
    repeat (100) @(negedge clk);
    chk("abort_nodone", 0, done_a[0], p);
    send(0, 12'h5A5);
    val_v[0] = 0;
    wait_done(0, p, 200);
    chk("word_5a5", 0, lw_a[0], 32'h35A5);

    for (int n = 0; n < 2000; n++) begin
      val_v[0] = ($urandom_range(0, 3) == 0);
      smp_v[0] = 12'($urandom);
      rst_v[0] = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst_v[0] = 0;
    val_v[0] = 0;

    wait_done(2, 0, 9000);
    chk("word_h255", 2, lw_a[2], 32'h3001);
    chk("rises_h255", 2, lr_a[2], 16);
    chk("cslow_h255", 2, lc_a[2], 8415);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter SCLK_HALF, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter CFG, default 4'b0011: upper frame nibble {A/B, BUF, GA_n, SHDN_n}, i.e. channel A, unbuffered, 1x gain, active.
REQ-003 clk  input  1  system clock (12 MHz); all logic SHALL be on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sample  input  12  unsigned DAC code (synth channel/mixer output, zero-extended).
REQ-006 sample_valid  input  1  sample holds a new value.
REQ-007 sample_ready  output  1  block can accept a sample this cycle.
REQ-008 dac_cs_n  output  1  SPI chip select, active low.
REQ-009 dac_sclk  output  1  SPI clock, idle low (mode 0).
REQ-010 dac_mosi  output  1  SPI data, MSB first.
REQ-011 dac_ldac_n  output  1  DAC latch strobe, active low.
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 Handshake: a sample SHALL be accepted on any cycle with sample_valid && sample_ready; sample SHALL be captured into an internal register that cycle, and later changes to sample SHALL NOT affect the frame.
REQ-014 sample_ready SHALL be 1 only in state IDLE with rst low; sample_valid while not ready SHALL be ignored, with no queuing.
REQ-015 Frame SHALL be 16 bits: {CFG[3:0], sample[11:0]}, MSB first.
REQ-016 States SHALL be IDLE, SETUP, SHIFT, GAP; IDLE->SETUP on accept, SETUP->SHIFT after SCLK_HALF cycles, SHIFT->GAP after 16th bit's low phase, GAP->IDLE after SCLK_HALF cycles.
REQ-017 SETUP: dac_cs_n=0, dac_sclk=0, dac_mosi=frame bit 15, starting the cycle after accept.
REQ-018 SHIFT: per bit, dac_sclk high SCLK_HALF cycles then low SCLK_HALF cycles; dac_mosi SHALL change only on the first low-phase cycle, to the next bit, and SHALL stay stable while dac_sclk is high.
REQ-019 Exactly 16 dac_sclk rising edges SHALL occur per frame; dac_cs_n SHALL stay low for exactly 33*SCLK_HALF cycles.
REQ-020 After bit 0's low phase, dac_cs_n SHALL go 1 and dac_mosi 0; frame_done SHALL pulse for 1 cycle on the first GAP cycle.
REQ-021 Accept-to-next-ready latency SHALL be 34*SCLK_HALF+1 cycles (69 at default); back-to-back frames SHALL achieve this rate.
REQ-022 Outside SETUP/SHIFT: dac_cs_n=1, dac_sclk=0, dac_mosi=0.
REQ-023 Bit and phase counters SHALL NOT wrap mid-frame; the 16-bit and SCLK_HALF=255 boundaries SHALL be covered by counter widths.

Reset
REQ-024 While rst=1: state IDLE, sample_ready=0, dac_cs_n=1, dac_sclk=0, dac_mosi=0, frame_done=0, dac_ldac_n per REQ-027/028; all counters 0.
REQ-025 rst asserted mid-frame SHALL abort the frame on the next edge with no further SCLK edges; sample_ready SHALL be 1 the first cycle rst is low.
REQ-026 rst and sample_valid in the same cycle: reset wins and no sample is accepted.

Configuration
REQ-027 Macro DAC_SPI_TX_LDAC_EN defined: dac_ldac_n SHALL be 1 except low for exactly SCLK_HALF cycles covering all of GAP, so each frame is latched after dac_cs_n rises; reset value 1.
REQ-028 Macro undefined: dac_ldac_n SHALL be constant 0, with the DAC latching on the dac_cs_n rising edge; all other timing SHALL be unchanged.

Verification
REQ-029 SCLK_HALF=2, sample=12'hA5C, one valid pulse -> MOSI sampled at SCLK rises = 16'h3A5C; 16 rises; cs_n low for 66 cycles; frame_done pulses once.
REQ-030 sample_valid held high with 12'h000 then 12'hFFF -> frames 16'h3000, 16'h3FFF; ready-to-ready spacing 69 cycles; ready=0 throughout each frame.
REQ-031 sample changed to 12'h123 the cycle after accepting 12'h800 -> frame carries 16'h3800; sample_valid asserted mid-frame is not accepted.
REQ-032 rst asserted after 5th SCLK rise -> next cycle cs_n=1, sclk=0, mosi=0, no further rises; ready=1 the cycle after rst drops; a new frame then completes normally.
REQ-033 SCLK_HALF=1 and SCLK_HALF=255 with sample 12'h001 -> cs_n low 33 / 8415 cycles; MOSI never changes while SCLK high.
REQ-034 With DAC_SPI_TX_LDAC_EN, SCLK_HALF=2 -> ldac_n low exactly 2 cycles starting the cycle cs_n rises; without it ldac_n stays 0.
